// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-Stream width packer: counter and keep widths
// derived from the packing ratio.
package axis_pkg;

  // Bits needed to count 0..n-1, never less than 1 so a counter always exists.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Width of the lane counter (next lane to fill) for a given ratio.
  function automatic int lane_cnt_w(input int ratio);
    return clog2_min1(ratio);
  endfunction

  // One keep bit per output lane.
  function automatic int keep_w(input int ratio);
    return ratio;
  endfunction

endpackage

// File: rtl/axis_width_packer_if.sv
// Bundle of the packer's narrow input stream, wide output stream and a
// debug view of the lane counter.
//
// Handshake semantics (both streams): a transfer happens on the rising aclk
// edge where valid && ready. Once valid is high it stays high, with payload
// stable, until the transfer; valid never depends on ready in the same cycle.
interface axis_width_packer_if
  import axis_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int LCW       = lane_cnt_w(RATIO);
  localparam int KW        = keep_w(RATIO);

  logic [IN_WIDTH-1:0]  s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic [OUT_WIDTH-1:0] m_data;
  logic [KW-1:0]        m_keep;
  logic                 m_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [LCW-1:0]       dbg_lane_cnt;

  // The packer itself.
  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_keep, m_last, m_valid, dbg_lane_cnt
  );

  // The surrounding source of beats and sink of words.
  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_keep, m_last, m_valid, dbg_lane_cnt
  );

endinterface

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream register slice holding data/keep/last/valid.
// The owner loads it only when free is high; free means empty or draining.
module axis_out_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              free
);

  assign free = !out_valid || out_ready;

  // Load a new word (possibly while the old one drains), otherwise drop
  // valid on drain; payload keeps its last value when not reloaded.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_width_packer.sv
// Narrow-to-wide AXI-Stream packer: gathers RATIO beats of IN_WIDTH bits
// into one word, little-endian by lane, flushing short frames as partial
// words with keep marking the filled lanes.
module axis_width_packer
  import axis_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input logic                aclk,
  input logic                aresetn,
  axis_width_packer_if.slave bus
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int LCW       = lane_cnt_w(RATIO);
  localparam int KW        = keep_w(RATIO);
  localparam int ACC_W     = (RATIO - 1) * IN_WIDTH;
  localparam logic [LCW-1:0] LAST_LANE = LCW'(RATIO - 1);

  logic [LCW-1:0]       lane_cnt;
  logic [ACC_W-1:0]     acc;
  logic                 out_free;
  logic                 accept;
  logic                 closing;
  logic                 last_lane;
  logic [OUT_WIDTH-1:0] word;
  logic [KW-1:0]        keep;

  // Input is taken only while the output slot is empty or draining, so a
  // closing beat always has somewhere to go; this passes m_ready through
  // combinationally to s_ready.
  assign bus.s_ready      = aresetn && out_free;
  assign accept           = bus.s_valid && bus.s_ready;
  assign last_lane        = (lane_cnt == LAST_LANE);
  assign closing          = accept && (bus.s_last || last_lane);
  assign bus.dbg_lane_cnt = lane_cnt;

  // Track the next lane to fill and park non-closing beats in the accumulator.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lane_cnt <= '0;
      acc      <= '0;
    end else if (closing) begin
      lane_cnt <= '0;
    end else if (accept) begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (lane_cnt == LCW'(k)) acc[k*IN_WIDTH +: IN_WIDTH] <= bus.s_data;
      end
      lane_cnt <= lane_cnt + LCW'(1);
    end
  end

  // Build the word for a closing beat: stored lanes below lane_cnt, the live
  // beat at lane_cnt, zeros above so frames never mix.
  always_comb begin
    word = '0;
    keep = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (LCW'(k) < lane_cnt) begin
        word[k*IN_WIDTH +: IN_WIDTH] = acc[k*IN_WIDTH +: IN_WIDTH];
        keep[k] = 1'b1;
      end else if (LCW'(k) == lane_cnt) begin
        word[k*IN_WIDTH +: IN_WIDTH] = bus.s_data;
        keep[k] = 1'b1;
      end
    end
    if (last_lane) begin
      word[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = bus.s_data;
      keep[RATIO-1] = 1'b1;
    end
  end

  axis_out_reg #(
    .DATA_W (OUT_WIDTH),
    .KEEP_W (KW)
  ) u_out_reg (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (closing),
    .in_data   (word),
    .in_keep   (keep),
    .in_last   (bus.s_last),
    .out_data  (bus.m_data),
    .out_keep  (bus.m_keep),
    .out_last  (bus.m_last),
    .out_valid (bus.m_valid),
    .out_ready (bus.m_ready),
    .free      (out_free)
  );

endmodule

// File: tb/tb_axis_width_packer.sv
// Bench for axis_width_packer: RATIO=4 instance checked every cycle against
// a queue-based model, plus a RATIO=3 instance with directed checks.
module tb_axis_width_packer;

  localparam int IW  = 8;
  localparam int R   = 4;
  localparam int OW  = IW * R;
  localparam int R3  = 3;
  localparam int OW3 = IW * R3;
  localparam int EW  = OW + R + 1;

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;

  axis_width_packer_if #(.IN_WIDTH(IW), .RATIO(R))  bus ();
  axis_width_packer_if #(.IN_WIDTH(IW), .RATIO(R3)) bus3 ();

  axis_width_packer #(.IN_WIDTH(IW), .RATIO(R)) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  axis_width_packer #(.IN_WIDTH(IW), .RATIO(R3)) u_dut3 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus3)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [IW-1:0] part[$];    // beats of the word being collected
  logic [EW-1:0] exp_q[$];   // {last, keep, data} words owed downstream
  int  cyc = 0;
  bit  mr_rand = 1'b0;
  bit  stream_mode = 1'b0;
  int  stream_words = 0;
  int  stream_lasts = 0;
  int  stream_last_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word formed from the collected beats: beat i sits at bits [8i +: 8],
  // keep has one bit per collected beat.
  function automatic logic [EW-1:0] pack_word(input logic last);
    logic [OW-1:0] d;
    logic [R-1:0]  k;
    d = '0;
    for (int i = 0; i < part.size(); i++) d = d | (OW'(part[i]) << (i * IW));
    k = R'((1 << part.size()) - 1);
    return {last, k, d};
  endfunction

  // ---------------- reference model ----------------
  initial begin : model
    bit in_hs;
    bit out_hs;
    forever begin
      @(posedge aclk or negedge aresetn);
      if (!aresetn) begin
        part.delete();
        exp_q.delete();
      end else begin
        cyc++;
        out_hs = (exp_q.size() != 0) && bus.m_ready;
        in_hs  = bus.s_valid && ((exp_q.size() == 0) || bus.m_ready);
        if (out_hs) void'(exp_q.pop_front());
        if (in_hs) begin
          part.push_back(bus.s_data);
          if (bus.s_last || part.size() == R) begin
            exp_q.push_back(pack_word(bus.s_last));
            part.delete();
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    logic [EW-1:0] e;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
        chk("rst_m_data",  64'(bus.m_data),  64'(0));
        chk("rst_m_keep",  64'(bus.m_keep),  64'(0));
        chk("rst_m_last",  64'(bus.m_last),  64'(0));
        chk("rst_s_ready", 64'(bus.s_ready), 64'(0));
        chk("rst_lane",    64'(bus.dbg_lane_cnt), 64'(0));
      end else begin
        chk("s_ready",  64'(bus.s_ready), 64'((exp_q.size() == 0) || bus.m_ready));
        chk("m_valid",  64'(bus.m_valid), 64'(exp_q.size() != 0));
        chk("lane_cnt", 64'(bus.dbg_lane_cnt), 64'(part.size()));
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("m_data", 64'(bus.m_data), 64'(e[OW-1:0]));
          chk("m_keep", 64'(bus.m_keep), 64'(e[OW +: R]));
          chk("m_last", 64'(bus.m_last), 64'(e[EW-1]));
        end
        if (stream_mode && bus.m_valid && bus.m_ready) begin
          if (stream_words > 0) chk("stream_gap", 64'(cyc - stream_last_cyc), 64'(4));
          stream_words++;
          if (bus.m_last) stream_lasts++;
          stream_last_cyc = cyc;
        end
      end
    end
  end

  // ---------------- random downstream readiness ----------------
  initial begin : mready_gen
    forever begin
      @(posedge aclk);
      #1;
      if (mr_rand) bus.m_ready = ($urandom_range(0, 99) < 65);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [IW-1:0] d, input logic l);
    bit done;
    int waited;
    done = 1'b0;
    waited = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    bus.s_last  = l;
    while (!done) begin
      @(negedge aclk);
      done = bus.s_ready;
      @(posedge aclk);
      #2;
      waited++;
      if (!done && waited >= 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: beat 0x%0h not accepted after %0d cycles", d, waited);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = IW'($urandom);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  // Literal expectations checked against both the DUT and the model head.
  task automatic pin(input string name, input logic [OW-1:0] d, input logic [R-1:0] k, input logic l);
    logic [EW-1:0] e;
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk({name, "_valid"}, 64'(bus.m_valid), 64'(1));
    chk({name, "_data"},  64'(bus.m_data),  64'(d));
    chk({name, "_keep"},  64'(bus.m_keep),  64'(k));
    chk({name, "_last"},  64'(bus.m_last),  64'(l));
    chk({name, "_model"}, 64'(e), 64'({l, k, d}));
  endtask

  task automatic pulse_reset();
    #1;
    aresetn = 1'b0;
    #1;
    chk("rst_now_m_valid", 64'(bus.m_valid), 64'(0));
    chk("rst_now_s_ready", 64'(bus.s_ready), 64'(0));
    chk("rst_now_m_data",  64'(bus.m_data),  64'(0));
    chk("rst_now_lane",    64'(bus.dbg_lane_cnt), 64'(0));
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #2;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int len;
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    bus3.s_valid = 1'b0; bus3.s_last = 1'b0; bus3.s_data = '0; bus3.m_ready = 1'b0;
    #1;
    aresetn = 1'b0;
    #1;
    chk("init_m_valid",  64'(bus.m_valid),  64'(0));
    chk("init_s_ready",  64'(bus.s_ready),  64'(0));
    chk("init3_m_valid", 64'(bus3.m_valid), 64'(0));
    chk("init3_s_ready", 64'(bus3.s_ready), 64'(0));
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #2;
    bus.m_ready  = 1'b1;
    bus3.m_ready = 1'b1;

    // Full word
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b1);
    idle(0);
    @(negedge aclk);
    pin("full", 32'h44332211, 4'b1111, 1'b1);
    @(posedge aclk); #2;
    idle(2);

    // Short frame, then next frame from lane 0
    send_beat(8'hA1, 1'b0);
    send_beat(8'hB2, 1'b1);
    idle(0);
    @(negedge aclk);
    pin("short", 32'h0000B2A1, 4'b0011, 1'b1);
    @(posedge aclk); #2;
    send_beat(8'hC3, 1'b0);
    send_beat(8'hD4, 1'b0);
    send_beat(8'hE5, 1'b0);
    send_beat(8'hF6, 1'b1);
    idle(0);
    @(negedge aclk);
    pin("next", 32'hF6E5D4C3, 4'b1111, 1'b1);
    @(posedge aclk); #2;
    idle(2);

    // Single-lane frame
    send_beat(8'h5A, 1'b1);
    idle(0);
    @(negedge aclk);
    pin("single", 32'h0000005A, 4'b0001, 1'b1);
    @(posedge aclk); #2;
    idle(2);

    // Backpressure with a pending word and beats waiting
    bus.m_ready = 1'b0;
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h04, 1'b0);
    bus.s_data = 8'h05; bus.s_valid = 1'b1; bus.s_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      pin("bp_hold", 32'h04030201, 4'b1111, 1'b0);
      chk("bp_s_ready", 64'(bus.s_ready), 64'(0));
      chk("bp_lane", 64'(bus.dbg_lane_cnt), 64'(0));
      @(posedge aclk); #2;
    end
    bus.m_ready = 1'b1;
    send_beat(8'h05, 1'b0);
    send_beat(8'h06, 1'b1);
    idle(0);
    @(negedge aclk);
    pin("bp_after", 32'h00000605, 4'b0011, 1'b1);
    @(posedge aclk); #2;
    idle(3);

    // Streaming 64 beats, frames of 8
    stream_mode = 1'b1;
    for (int i = 0; i < 64; i++) send_beat(IW'(i), (i % 8) == 7);
    idle(4);
    stream_mode = 1'b0;
    chk("stream_words", 64'(stream_words), 64'(16));
    chk("stream_lasts", 64'(stream_lasts), 64'(8));

    // Reset with a partial word in the accumulator
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    idle(0);
    pulse_reset();
    bus.m_ready = 1'b1;
    send_beat(8'h31, 1'b0);
    send_beat(8'h32, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h34, 1'b1);
    idle(0);
    @(negedge aclk);
    pin("post_rst1", 32'h34333231, 4'b1111, 1'b1);
    @(posedge aclk); #2;
    idle(2);

    // Reset with an output word pending
    bus.m_ready = 1'b0;
    send_beat(8'h41, 1'b0);
    send_beat(8'h42, 1'b0);
    send_beat(8'h43, 1'b0);
    send_beat(8'h44, 1'b0);
    idle(0);
    pulse_reset();
    bus.m_ready = 1'b1;
    send_beat(8'h51, 1'b0);
    send_beat(8'h52, 1'b1);
    idle(0);
    @(negedge aclk);
    pin("post_rst2", 32'h00005251, 4'b0011, 1'b1);
    @(posedge aclk); #2;
    idle(2);

    // Random frames with random downstream stalls and input gaps
    mr_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 9);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_beat(IW'($urandom), b == len - 1);
      end
    end
    idle(0);
    mr_rand = 1'b0;
    bus.m_ready = 1'b1;
    idle(5);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("drain_m_valid", 64'(bus.m_valid), 64'(0));

    // RATIO=3 instance: 01,02,03,04 with last on 04
    bus3.s_data = 8'h01; bus3.s_valid = 1'b1; bus3.s_last = 1'b0;
    @(negedge aclk);
    chk("r3_s_ready", 64'(bus3.s_ready), 64'(1));
    @(posedge aclk); #2;
    bus3.s_data = 8'h02;
    @(posedge aclk); #2;
    bus3.s_data = 8'h03;
    @(posedge aclk); #2;
    bus3.s_data = 8'h04; bus3.s_last = 1'b1;
    @(negedge aclk);
    chk("r3_w0_valid", 64'(bus3.m_valid), 64'(1));
    chk("r3_w0_data",  64'(bus3.m_data),  64'(24'h030201));
    chk("r3_w0_keep",  64'(bus3.m_keep),  64'(3'b111));
    chk("r3_w0_last",  64'(bus3.m_last),  64'(0));
    @(posedge aclk); #2;
    bus3.s_valid = 1'b0; bus3.s_last = 1'b0;
    @(negedge aclk);
    chk("r3_w1_valid", 64'(bus3.m_valid), 64'(1));
    chk("r3_w1_data",  64'(bus3.m_data),  64'(24'h000004));
    chk("r3_w1_keep",  64'(bus3.m_keep),  64'(3'b001));
    chk("r3_w1_last",  64'(bus3.m_last),  64'(1));
    @(posedge aclk); #2;
    @(negedge aclk);
    chk("r3_idle_valid", 64'(bus3.m_valid), 64'(0));
    chk("r3_width", 64'(OW3), 64'($bits(bus3.m_data)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
